// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Debounces NUM_KEYS raw push-button pins. Each pin is normalized so that
// 1 = pressed, synchronized through two flops, then accepted as a new level
// only after DEBOUNCE_CYCLES consecutive cycles that disagree with the
// current stable level. Accepted edges produce one-cycle press/release pulses.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   key_n        in   [NUM_KEYS] raw button pins (polarity per ACTIVE_LOW)
//   key_state    out  [NUM_KEYS] registered debounced level, 1 = pressed
//   key_press    out  [NUM_KEYS] registered one-cycle pulse on accepted press
//   key_release  out  [NUM_KEYS] registered one-cycle pulse on accepted release
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] w_pressed;
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic [CNT_W-1:0]    r_cnt     [NUM_KEYS];

    logic [NUM_KEYS-1:0] w_stable_nxt;
    logic [NUM_KEYS-1:0] w_press_nxt;
    logic [NUM_KEYS-1:0] w_release_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt [NUM_KEYS];

    // Normalize pin polarity so downstream logic always sees 1 = pressed
    assign w_pressed = (ACTIVE_LOW != 0) ? ~key_n : key_n;

    // Two-flop synchronizer per key
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pressed;
            r_sync2 <= r_sync1;
        end
    end

    // Per-key acceptance: count consecutive disagreeing samples; any agreeing
    // sample restarts the count, so the counter tops out at CNT_LAST
    always_comb begin
        w_stable_nxt  = r_stable;
        w_press_nxt   = '0;
        w_release_nxt = '0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            w_cnt_nxt[k] = '0;
            if (r_sync2[k] != r_stable[k]) begin
                if (r_cnt[k] == CNT_LAST) begin
                    w_stable_nxt[k]  = r_sync2[k];
                    w_press_nxt[k]   = r_sync2[k];
                    w_release_nxt[k] = ~r_sync2[k];
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Counter, stable level and pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable  <= '0;
            r_press   <= '0;
            r_release <= '0;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_stable  <= w_stable_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            for (int k = 0; k < int'(NUM_KEYS); k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    assign key_state   = r_stable;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
// Directed self-checking bench for key_debounce with DEBOUNCE_CYCLES = 4,
// ACTIVE_LOW = 1, NUM_KEYS = 2. Pins change on the falling edge before each
// rising edge; outputs are sampled 1 time unit after each rising edge.
// Edge numbering: edge 1 is the first rising edge that samples a new pin level.
// ---------------------------------------------------------------------------
module tb_key_debounce;

    localparam int unsigned NK = 2;
    localparam int unsigned DC = 4;

    logic          clk;
    logic          reset_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int n_checks;
    int n_errors;

    key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0;
        key_n   = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        if (key_state !== 2'b00) begin
            $display("FAIL reset_state: got %b want 00", key_state); n_errors++;
        end
        n_checks++;
        if (key_press !== 2'b00) begin
            $display("FAIL reset_press: got %b want 00", key_press); n_errors++;
        end
        n_checks++;
        if (key_release !== 2'b00) begin
            $display("FAIL reset_release: got %b want 00", key_release); n_errors++;
        end
        n_checks++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Key 0 pressed cleanly and held, then released cleanly
    task automatic test_clean_press();
        logic [NK-1:0] es, ep, er;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk); key_n = 2'b10;
            @(posedge clk); #1;
            es = (e >= 6) ? 2'b01 : 2'b00;
            ep = (e == 6) ? 2'b01 : 2'b00;
            er = 2'b00;
            if (key_state !== es || key_press !== ep || key_release !== er) begin
                $display("FAIL clean_press edge %0d: got state=%b press=%b release=%b want %b %b %b",
                         e, key_state, key_press, key_release, es, ep, er);
                n_errors++;
            end
            n_checks++;
        end
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk); key_n = 2'b11;
            @(posedge clk); #1;
            es = (e >= 6) ? 2'b00 : 2'b01;
            ep = 2'b00;
            er = (e == 6) ? 2'b01 : 2'b00;
            if (key_state !== es || key_press !== ep || key_release !== er) begin
                $display("FAIL clean_release edge %0d: got state=%b press=%b release=%b want %b %b %b",
                         e, key_state, key_press, key_release, es, ep, er);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    // Key 0 low 3, high 1, then low held: accept 6 edges after final fall
    task automatic test_bounce();
        logic [NK-1:0] es, ep, pin;
        int            n_press;
        n_press = 0;
        for (int e = 1; e <= 13; e++) begin
            pin = (e == 4) ? 2'b11 : 2'b10;
            @(negedge clk); key_n = pin;
            @(posedge clk); #1;
            es = (e >= 10) ? 2'b01 : 2'b00;
            ep = (e == 10) ? 2'b01 : 2'b00;
            if (key_press[0] === 1'b1) n_press++;
            if (key_state !== es || key_press !== ep || key_release !== 2'b00) begin
                $display("FAIL bounce edge %0d: got state=%b press=%b release=%b want %b %b 00",
                         e, key_state, key_press, key_release, es, ep);
                n_errors++;
            end
            n_checks++;
        end
        if (n_press != 1) begin
            $display("FAIL bounce_pulse_count: got %0d want 1", n_press); n_errors++;
        end
        n_checks++;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk); key_n = 2'b11;
            @(posedge clk);
        end
        #1;
        if (key_state !== 2'b00) begin
            $display("FAIL bounce_settle: got %b want 00", key_state); n_errors++;
        end
        n_checks++;
    endtask

    // Key 1 low for 3 cycles only: never accepted
    task automatic test_glitch();
        logic [NK-1:0] pin;
        for (int e = 1; e <= 12; e++) begin
            pin = (e <= 3) ? 2'b01 : 2'b11;
            @(negedge clk); key_n = pin;
            @(posedge clk); #1;
            if (key_state !== 2'b00 || key_press !== 2'b00 || key_release !== 2'b00) begin
                $display("FAIL glitch edge %0d: got state=%b press=%b release=%b want 00 00 00",
                         e, key_state, key_press, key_release);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    // Both keys pressed then released together
    task automatic test_simultaneous();
        logic [NK-1:0] es, ep, er;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk); key_n = 2'b00;
            @(posedge clk); #1;
            es = (e >= 6) ? 2'b11 : 2'b00;
            ep = (e == 6) ? 2'b11 : 2'b00;
            if (key_state !== es || key_press !== ep || key_release !== 2'b00) begin
                $display("FAIL simul_press edge %0d: got state=%b press=%b release=%b want %b %b 00",
                         e, key_state, key_press, key_release, es, ep);
                n_errors++;
            end
            n_checks++;
        end
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk); key_n = 2'b11;
            @(posedge clk); #1;
            es = (e >= 6) ? 2'b00 : 2'b11;
            er = (e == 6) ? 2'b11 : 2'b00;
            if (key_state !== es || key_press !== 2'b00 || key_release !== er) begin
                $display("FAIL simul_release edge %0d: got state=%b press=%b release=%b want %b 00 %b",
                         e, key_state, key_press, key_release, es, er);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    // Reset two cycles into a press; key still held when reset releases
    task automatic test_reset_mid_count();
        logic [NK-1:0] es, ep;
        for (int e = 1; e <= 2; e++) begin
            @(negedge clk); key_n = 2'b10;
            @(posedge clk);
        end
        @(negedge clk); reset_n = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            if (key_state !== 2'b00 || key_press !== 2'b00 || key_release !== 2'b00) begin
                $display("FAIL rst_mid_during edge %0d: got state=%b press=%b release=%b want 00 00 00",
                         e, key_state, key_press, key_release);
                n_errors++;
            end
            n_checks++;
        end
        @(negedge clk); reset_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            es = (e >= 6) ? 2'b01 : 2'b00;
            ep = (e == 6) ? 2'b01 : 2'b00;
            if (key_state !== es || key_press !== ep || key_release !== 2'b00) begin
                $display("FAIL rst_mid_after edge %0d: got state=%b press=%b release=%b want %b %b 00",
                         e, key_state, key_press, key_release, es, ep);
                n_errors++;
            end
            n_checks++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2, number of independent push-button channels; this matches the 2-bit in_port of the downstream key PIO.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), consecutive stable cycles required to accept a new level; legal range 1..2^20.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning key_n pins read 0 when pressed; 0 means the pins read 1 when pressed.
REQ-004 SHALL have port clk, input, 1, system clock; all state SHALL be clocked on the rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port key_n, input, NUM_KEYS, raw asynchronous button pins.
REQ-007 SHALL have port key_state, output, NUM_KEYS, registered debounced level, 1 = pressed; it feeds the key PIO in_port.
REQ-008 SHALL have port key_press, output, NUM_KEYS, registered one-cycle pulse on each accepted press.
REQ-009 SHALL have port key_release, output, NUM_KEYS, registered one-cycle pulse on each accepted release.

Function
REQ-010 Each pin SHALL be normalized to pressed = 1 (inverted when ACTIVE_LOW = 1, otherwise passed through) and then passed through a 2-flop synchronizer per key.
REQ-011 Each key SHALL have an independent counter of width clog2(DEBOUNCE_CYCLES)+1 bits and a stable bit; the stable bit drives key_state.
REQ-012 When the synchronizer output equals the stable bit, the counter SHALL clear to 0 on the next edge.
REQ-013 When the synchronizer output differs from the stable bit and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 When the synchronizer output differs from the stable bit and the counter equals DEBOUNCE_CYCLES-1, then on that edge:
- the stable bit SHALL take the new level;
- the counter SHALL clear;
- key_press (new level 1) or key_release (new level 0) SHALL be 1 for exactly one cycle, coincident with the key_state change.
REQ-015 Latency: counting the first edge that samples the new pin level as edge 1, key_state SHALL change on edge DEBOUNCE_CYCLES+2, provided the pin holds throughout.
REQ-016 A bounce, meaning any sample matching the stable bit before acceptance, SHALL restart the count from 0; pulses shorter than DEBOUNCE_CYCLES cycles SHALL never change key_state.
REQ-017 The counter SHALL never exceed DEBOUNCE_CYCLES-1, and wrap-around SHALL be impossible.
REQ-018 With DEBOUNCE_CYCLES = 1, a mismatch SHALL be accepted on the first edge it is seen, giving a latency of 3 edges.
REQ-019 Keys SHALL be fully independent; simultaneous transitions on several keys SHALL each be accepted and pulsed in the same cycle.
REQ-020 key_press and key_release for the same key SHALL never be asserted together.

Reset
REQ-021 With reset_n = 0, the block SHALL asynchronously clear:
- synchronizer flops to 0 (not pressed);
- counters to 0;
- key_state, key_press and key_release to 0.
REQ-022 Reset asserted mid-debounce SHALL discard the partial count; after release, the bench SHALL see no pulses until a full DEBOUNCE_CYCLES acceptance completes.
REQ-023 A key held pressed through reset release SHALL be accepted as a press DEBOUNCE_CYCLES+2 edges after reset deassertion, and key_press SHALL pulse.

Verification (DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 1, NUM_KEYS = 2)
REQ-024 Clean press: drive key_n 11 -> 10 and hold -> key_state = 01 on edge 6, key_press = 01 for one cycle, key_release = 00.
REQ-025 Bounce: key_n[0] low for 3 cycles, high for 1, then low and held -> no change until 6 edges after the final fall; exactly one key_press pulse.
REQ-026 Glitch: key_n[1] low for 3 cycles, then high -> key_state stays 00 and no pulses occur.
REQ-027 Simultaneous: key_n 11 -> 00 held, then 00 -> 11 held -> key_press = 11 in one cycle, later key_release = 11 in one cycle.
REQ-028 Reset mid-count: assert reset_n = 0 two cycles after key_n[0] falls, release it with the key still held -> key_state = 00 during reset, then 01 on edge 6 after release, with one key_press pulse.
